// File: rtl/uart_pkg.sv
// Shared types and register map for the MMIO UART.
// FSM states, register offsets and STATUS bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam logic TXDATA = 1'b0;
  localparam logic STATUS = 1'b1;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers.
// A pop frees a slot for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q <= wptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO
// and a STATUS register on the load path.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic        i_re,
  input  logic        i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_tx
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          ovf_q;
  logic          ovf_d;
  logic [31:0]   rdata_q;
  logic [31:0]   status;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          tick;
  logic          ovf_set;
  logic          ovf_clr;
  logic [7:0]    head;
  logic          unused_wdata;

  assign unused_wdata = ^i_wdata[31:8];

  assign push    = i_sel && i_we && (i_addr == TXDATA);
  assign ovf_clr = i_sel && i_we && (i_addr == STATUS) &&
                   i_wdata[ST_OVF];
  assign tick    = (cnt_q == '0);
  assign pop     = !empty &&
                   ((state_q == IDLE) || (state_q == STOP && tick));
  assign ovf_set = push && full && !pop;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (i_clk),
    .rst_ni (i_rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(i_wdata[7:0]),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty)
  );

  always_comb begin
    status           = '0;
    status[ST_FULL]  = full;
    status[ST_EMPTY] = empty;
    status[ST_BUSY]  = (state_q != IDLE);
    status[ST_OVF]   = ovf_q;
  end

  // A new overflow outranks a clear in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      if (i_sel && i_re) begin
        rdata_q <= (i_addr == STATUS) ? status : '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= head;
            cnt_q   <= CNT_LD;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            cnt_q   <= CNT_LD;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        DATA: begin
          if (tick) begin
            cnt_q <= CNT_LD;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              idx_q   <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        STOP: begin
          if (tick) begin
            if (pop) begin
              shift_q <= head;
              cnt_q   <= CNT_LD;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
      endcase
    end
  end

  assign o_tx    = tx_q;
  assign o_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: random bytes checked against
// an arithmetic model of the expected serial line.
module tb_mmio_uart_tx;
  import uart_pkg::*;

  localparam int D = 4;
  localparam int FR = 10 * D;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_sel = 1'b0;
  logic        i_we = 1'b0;
  logic        i_re = 1'b0;
  logic        i_addr = 1'b0;
  logic [31:0] i_wdata = '0;
  logic [31:0] o_rdata;
  logic        o_tx;

  int errs = 0;
  int checks = 0;

  logic       cap_en = 1'b0;
  logic       cap_q[$];
  logic [7:0] exp_q[$];

  mmio_uart_tx #(
    .CLK_DIV(D),
    .FIFO_DEPTH(4)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sel  (i_sel),
    .i_we   (i_we),
    .i_re   (i_re),
    .i_addr (i_addr),
    .i_wdata(i_wdata),
    .o_rdata(o_rdata),
    .o_tx   (o_tx)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (cap_en) cap_q.push_back(o_tx);
  end

  // Sample 0 is the cycle after the first write edge and
  // must still be idle; then frames follow back to back.
  function automatic logic exp_bit(int k);
    int kk, f, b;
    if (k < 1) return 1'b1;
    kk = k - 1;
    f = kk / FR;
    b = (kk % FR) / D;
    if (f >= exp_q.size()) return 1'b1;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return exp_q[f][b-1];
  endfunction

  task automatic tick(int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic store(logic a, logic [31:0] d);
    i_sel = 1'b1;
    i_we = 1'b1;
    i_addr = a;
    i_wdata = d;
    tick(1);
    i_sel = 1'b0;
    i_we = 1'b0;
  endtask

  task automatic load(logic a);
    i_sel = 1'b1;
    i_re = 1'b1;
    i_addr = a;
    tick(1);
    i_sel = 1'b0;
    i_re = 1'b0;
  endtask

  task automatic wait_cap(int n);
    int lim;
    lim = n + 100;
    while (cap_q.size() < n && lim > 0) begin
      tick(1);
      lim--;
    end
    cap_en = 1'b0;
  endtask

  task automatic start_cap();
    cap_q.delete();
    cap_en = 1'b1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    tick(3);
    checks++;
    if (o_tx !== 1'b1) begin
      errs++;
      $display("FAIL rst_tx got=%b exp=1", o_tx);
    end
    checks++;
    if (o_rdata !== 32'h0) begin
      errs++;
      $display("FAIL rst_rdata got=%h exp=0", o_rdata);
    end
    i_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      checks++;
      if (o_tx !== 1'b1) begin
        errs++;
        $display("FAIL idle_tx cyc=%0d got=%b exp=1", i, o_tx);
      end
    end
    load(STATUS);
    checks++;
    if (o_rdata !== 32'h2) begin
      errs++;
      $display("FAIL idle_status got=%h exp=2", o_rdata);
    end
    tick(2);
    checks++;
    if (o_rdata !== 32'h2) begin
      errs++;
      $display("FAIL rdata_hold got=%h exp=2", o_rdata);
    end
    load(TXDATA);
    checks++;
    if (o_rdata !== 32'h0) begin
      errs++;
      $display("FAIL txdata_rd got=%h exp=0", o_rdata);
    end
  endtask

  task automatic test_single_frame(logic [7:0] b);
    int n, bad;
    logic got;
    exp_q.delete();
    exp_q.push_back(b);
    store(TXDATA, {$urandom, 8'h00} | {24'h0, b});
    start_cap();
    n = 1 + FR + 3;
    wait_cap(n);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      checks++;
      got = (k < cap_q.size()) ? cap_q[k] : 1'bx;
      if (got !== exp_bit(k)) begin
        errs++;
        bad++;
        if (bad <= 2)
          $display("FAIL frame byte=%h k=%0d got=%b exp=%b",
                   b, k, got, exp_bit(k));
      end
    end
    load(STATUS);
    checks++;
    if (o_rdata !== 32'h2) begin
      errs++;
      $display("FAIL post_frame_status got=%h exp=2", o_rdata);
    end
  endtask

  task automatic test_overflow();
    int n, bad;
    logic got;
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 5) exp_q.push_back(b);
      store(TXDATA, {24'h0, b});
      if (i == 0) start_cap();
    end
    load(STATUS);
    checks++;
    if (o_rdata !== 32'hD) begin
      errs++;
      $display("FAIL ovf_status got=%h exp=d", o_rdata);
    end
    n = 1 + 5 * FR + 4;
    wait_cap(n);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      checks++;
      got = (k < cap_q.size()) ? cap_q[k] : 1'bx;
      if (got !== exp_bit(k)) begin
        errs++;
        bad++;
        if (bad <= 2)
          $display("FAIL ovf_stream k=%0d got=%b exp=%b",
                   k, got, exp_bit(k));
      end
    end
    load(STATUS);
    checks++;
    if (o_rdata !== 32'hA) begin
      errs++;
      $display("FAIL ovf_sticky got=%h exp=a", o_rdata);
    end
    store(STATUS, 32'hFFFF_FFF7);
    load(STATUS);
    checks++;
    if (o_rdata !== 32'hA) begin
      errs++;
      $display("FAIL ovf_noclr got=%h exp=a", o_rdata);
    end
    store(STATUS, 32'h8);
    load(STATUS);
    checks++;
    if (o_rdata !== 32'h2) begin
      errs++;
      $display("FAIL ovf_clr got=%h exp=2", o_rdata);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255)) & 8'hF7;
    store(TXDATA, {24'h0, b});
    store(TXDATA, 32'h0000_0055);
    load(STATUS);
    checks++;
    if (o_rdata !== 32'h4) begin
      errs++;
      $display("FAIL mid_status got=%h exp=4", o_rdata);
    end
    tick(15);
    checks++;
    if (o_tx !== 1'b0) begin
      errs++;
      $display("FAIL bit3_low got=%b exp=0", o_tx);
    end
    #2;
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_tx !== 1'b1) begin
      errs++;
      $display("FAIL async_rst_tx got=%b exp=1", o_tx);
    end
    checks++;
    if (o_rdata !== 32'h0) begin
      errs++;
      $display("FAIL async_rst_rdata got=%h exp=0", o_rdata);
    end
    tick(2);
    i_rst = 1'b1;
    exp_q.delete();
    start_cap();
    load(STATUS);
    checks++;
    if (o_rdata !== 32'h2) begin
      errs++;
      $display("FAIL post_rst_status got=%h exp=2", o_rdata);
    end
    wait_cap(50);
    for (int k = 0; k < 50; k++) begin
      checks++;
      if (k >= cap_q.size() || cap_q[k] !== 1'b1) begin
        errs++;
        $display("FAIL post_rst_idle k=%0d exp=1", k);
        break;
      end
    end
  endtask

  task automatic test_pop_while_full();
    int n, bad;
    logic got;
    logic [7:0] b;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      store(TXDATA, {24'h0, b});
      if (i == 0) start_cap();
    end
    tick(36);
    b = 8'($urandom_range(0, 255));
    exp_q.push_back(b);
    store(TXDATA, {24'h0, b});
    load(STATUS);
    checks++;
    if (o_rdata !== 32'h5) begin
      errs++;
      $display("FAIL popfull_status got=%h exp=5", o_rdata);
    end
    n = 1 + 6 * FR + 4;
    wait_cap(n);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      checks++;
      got = (k < cap_q.size()) ? cap_q[k] : 1'bx;
      if (got !== exp_bit(k)) begin
        errs++;
        bad++;
        if (bad <= 2)
          $display("FAIL popfull_stream k=%0d got=%b exp=%b",
                   k, got, exp_bit(k));
      end
    end
    load(STATUS);
    checks++;
    if (o_rdata !== 32'h2) begin
      errs++;
      $display("FAIL popfull_end got=%h exp=2", o_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame(8'hA5);
    for (int i = 0; i < 3; i++) begin
      test_single_frame(8'($urandom_range(0, 255)));
    end
    test_overflow();
    test_reset_mid_frame();
    test_pop_while_full();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
